// File: rtl/csr_test_monitor.sv
// CSR test monitor: watches per-hart status-CSR writes after a start request and
// reports per-channel pass/fail, the first failing channel, and a run-cycle timeout.
module csr_test_monitor #(
  parameter int NUM_CH         = 2,
  parameter int DATA_W         = 32,
  parameter int CYC_W          = 32,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int SETTLE_CYCLES  = 10,
  parameter int ENC_MODE       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        csr_we,
  input  logic [NUM_CH*DATA_W-1:0] csr_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH-1:0]        ch_fail,
  output logic [2:0]               first_fail_ch,
  output logic [DATA_W-1:0]        first_fail_code,
  output logic [CYC_W-1:0]         cycle_count
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
  logic [CYC_W-1:0]  cycle_count_q, cycle_count_d;
  logic [NUM_CH-1:0] ch_done_q, ch_done_d;
  logic [NUM_CH-1:0] ch_fail_q, ch_fail_d;
  logic [2:0]        first_fail_ch_q, first_fail_ch_d;
  logic [DATA_W-1:0] first_fail_code_q, first_fail_code_d;
  logic              timeout_q, timeout_d;

  logic [NUM_CH-1:0] lat;
  logic [NUM_CH-1:0] lat_fail;
  logic              new_fail;
  logic [2:0]        new_fail_ch;
  logic [DATA_W-1:0] new_fail_code;
  logic [DATA_W-1:0] wd;
  logic              all_done;
  logic              tmo_hit;

  // Per-channel latch candidates this cycle; lowest index wins a same-cycle fail tie.
  always_comb begin
    lat           = '0;
    lat_fail      = '0;
    new_fail      = 1'b0;
    new_fail_ch   = '0;
    new_fail_code = '0;
    wd            = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wd = csr_wdata[i*DATA_W +: DATA_W];
      if (csr_we[i] && (wd != '0) && !ch_done_q[i]) begin
        lat[i]      = 1'b1;
        lat_fail[i] = (wd != DATA_W'(1));
        if (lat_fail[i] && !new_fail) begin
          new_fail      = 1'b1;
          new_fail_ch   = 3'(i);
          new_fail_code = (ENC_MODE == 1) ? (wd >> 1) : wd;
        end
      end
    end
  end

  assign all_done = &(ch_done_q | lat);
  assign tmo_hit  = (cycle_count_q == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_SETTLE;
      S_SETTLE: if (settle_cnt_q == SETTLE_LAST) state_d = S_RUN;
      S_RUN:    if (all_done || tmo_hit) state_d = S_DONE;
      S_DONE:   if (start) state_d = S_SETTLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    settle_cnt_d      = settle_cnt_q;
    cycle_count_d     = cycle_count_q;
    ch_done_d         = ch_done_q;
    ch_fail_d         = ch_fail_q;
    first_fail_ch_d   = first_fail_ch_q;
    first_fail_code_d = first_fail_code_q;
    timeout_d         = timeout_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          settle_cnt_d      = '0;
          cycle_count_d     = '0;
          ch_done_d         = '0;
          ch_fail_d         = '0;
          first_fail_ch_d   = '0;
          first_fail_code_d = '0;
          timeout_d         = 1'b0;
        end
      end
      S_SETTLE: settle_cnt_d = settle_cnt_q + SW'(1);
      S_RUN: begin
        ch_done_d = ch_done_q | lat;
        ch_fail_d = ch_fail_q | lat_fail;
        if (new_fail && !(|ch_fail_q)) begin
          first_fail_ch_d   = new_fail_ch;
          first_fail_code_d = new_fail_code;
        end
        // A timeout leaves the count at the budget's last index; completion counts its cycle.
        if (tmo_hit && !all_done) begin
          timeout_d = 1'b1;
        end else begin
          cycle_count_d = cycle_count_q + CYC_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_q      <= '0;
      cycle_count_q     <= '0;
      ch_done_q         <= '0;
      ch_fail_q         <= '0;
      first_fail_ch_q   <= '0;
      first_fail_code_q <= '0;
      timeout_q         <= 1'b0;
    end else begin
      settle_cnt_q      <= settle_cnt_d;
      cycle_count_q     <= cycle_count_d;
      ch_done_q         <= ch_done_d;
      ch_fail_q         <= ch_fail_d;
      first_fail_ch_q   <= first_fail_ch_d;
      first_fail_code_q <= first_fail_code_d;
      timeout_q         <= timeout_d;
    end
  end

  always_comb begin
    busy            = (state_q == S_SETTLE) || (state_q == S_RUN);
    done            = (state_q == S_DONE);
    pass            = (state_q == S_DONE) && !timeout_q && !(|ch_fail_q);
    timeout         = (state_q == S_DONE) && timeout_q;
    ch_done         = ch_done_q;
    ch_fail         = ch_fail_q;
    first_fail_ch   = first_fail_ch_q;
    first_fail_code = first_fail_code_q;
    cycle_count     = cycle_count_q;
  end

endmodule

// File: tb/tb_csr_test_monitor.sv
// Randomized bench for csr_test_monitor: per-run write schedules are scored against a
// model that derives results directly from each channel's first valid write cycle.
module tb_csr_test_monitor;

  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int TMO = 50;
  localparam int SET = 3;
  localparam int NEVER = 1000;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NCH-1:0]    csr_we;
  logic [NCH*DW-1:0] csr_wdata;
  logic              busy, done, pass, timeout;
  logic [NCH-1:0]    ch_done, ch_fail;
  logic [2:0]        first_fail_ch;
  logic [DW-1:0]     first_fail_code;
  logic [CW-1:0]     cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  int          first_c[NCH];
  logic [31:0] val[NCH];

  csr_test_monitor #(
    .NUM_CH(NCH), .DATA_W(DW), .CYC_W(CW),
    .TIMEOUT_CYCLES(TMO), .SETTLE_CYCLES(SET), .ENC_MODE(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .ch_done(ch_done), .ch_fail(ch_fail), .first_fail_ch(first_fail_ch),
    .first_fail_code(first_fail_code), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_case(input string name, input bit noise);
    int          end_c;
    bit          to;
    int          k;
    int          ff_c;
    int          ff_ch;
    logic [31:0] ff_code;
    logic [NCH-1:0] e_done, e_fail;
    // Reference: end of run is the latest first-write cycle, or the budget edge.
    to    = 1'b0;
    end_c = 0;
    for (int c = 0; c < NCH; c++) begin
      if (first_c[c] >= TMO) to = 1'b1;
      else if (first_c[c] > end_c) end_c = first_c[c];
    end
    if (to) end_c = TMO - 1;
    e_done  = '0;
    e_fail  = '0;
    ff_c    = NEVER * 2;
    ff_ch   = 0;
    ff_code = '0;
    for (int c = 0; c < NCH; c++) begin
      if (first_c[c] <= end_c) begin
        e_done[c] = 1'b1;
        if (val[c] != 32'd1) begin
          e_fail[c] = 1'b1;
          if (first_c[c] < ff_c) begin
            ff_c    = first_c[c];
            ff_ch   = c;
            ff_code = val[c] >> 1;
          end
        end
      end
    end

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({name, "/busy_after_start"}, {busy, done}, 2'b10);
    check({name, "/cleared"}, {ch_done, ch_fail, timeout, pass, cycle_count}, '0);
    for (int s = 0; s < SET; s++) begin
      csr_we    = '1;
      csr_wdata = '0;
      for (int c = 0; c < NCH; c++) csr_wdata[c*DW +: DW] = 32'd1;
      start = noise && ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end

    k = 0;
    while (done !== 1'b1 && k < TMO + 10) begin
      check({name, "/run_count"}, cycle_count, k);
      check({name, "/run_flags"}, {pass, timeout, busy}, 3'b001);
      csr_we    = '0;
      csr_wdata = '0;
      start     = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (k == first_c[c]) begin
          csr_we[c] = 1'b1;
          csr_wdata[c*DW +: DW] = val[c];
        end else if (noise && $urandom_range(0, 3) == 0) begin
          csr_we[c] = 1'b1;
          csr_wdata[c*DW +: DW] = (k < first_c[c]) ? 32'd0 : $urandom;
        end
      end
      if (noise && $urandom_range(0, 15) == 0) start = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    csr_we = '0;
    start  = 1'b0;

    check({name, "/latency"}, k, end_c + 1);
    for (int h = 0; h < 3; h++) begin
      check({name, "/state"}, {busy, done}, 2'b01);
      check({name, "/pass"}, pass, !to && (e_fail == '0));
      check({name, "/timeout"}, timeout, to);
      check({name, "/ch_done"}, ch_done, e_done);
      check({name, "/ch_fail"}, ch_fail, e_fail);
      check({name, "/ff_ch"}, first_fail_ch, (e_fail != '0) ? ff_ch : 0);
      check({name, "/ff_code"}, first_fail_code, ff_code);
      check({name, "/count"}, cycle_count, to ? (TMO - 1) : (end_c + 1));
      csr_we    = '1;
      csr_wdata = {$urandom, $urandom};
      @(posedge clk); #1;
      csr_we = '0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    csr_we    = '0;
    csr_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, pass, timeout, ch_done, ch_fail,
                            first_fail_ch, first_fail_code, cycle_count}, '0);
    rst = 1'b0;

    first_c = '{5, 9};     val = '{32'd1, 32'd1};    run_case("both_pass", 1'b0);
    first_c = '{4, 3};     val = '{32'h5, 32'h7};    run_case("ch1_fails_first", 1'b0);
    first_c = '{7, NEVER}; val = '{32'd1, 32'd1};    run_case("timeout", 1'b0);
    first_c = '{10, TMO-1}; val = '{32'd1, 32'd1};   run_case("last_cycle_complete", 1'b0);
    first_c = '{6, 6};     val = '{32'd4, 32'd9};    run_case("same_cycle_tie", 1'b0);
    first_c = '{TMO-1, 2}; val = '{32'd3, 32'd8};    run_case("fail_on_budget_edge", 1'b0);

    // Reset in the middle of a run with ch0 already latched; start held alongside rst.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (SET) @(posedge clk);
    #1;
    csr_we = 2'b01;
    csr_wdata = '0;
    csr_wdata[0 +: DW] = 32'd1;
    @(posedge clk); #1 csr_we = '0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_run/pre_reset", {busy, ch_done}, {1'b1, 2'b01});
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check("mid_run/reset_outputs", {busy, done, pass, timeout, ch_done, ch_fail,
                                    first_fail_ch, first_fail_code, cycle_count}, '0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_run/idle_after", {busy, done}, 2'b00);
    first_c = '{2, 8}; val = '{32'd1, 32'd1}; run_case("after_reset", 1'b0);

    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < NCH; c++) begin
        first_c[c] = $urandom_range(0, TMO + 5);
        case ($urandom_range(0, 3))
          0, 1:    val[c] = 32'd1;
          2:       val[c] = $urandom_range(2, 9);
          default: begin
            val[c] = $urandom;
            if (val[c] == 32'd0) val[c] = 32'd6;
          end
        endcase
      end
      if ($urandom_range(0, 4) == 0) first_c[1] = first_c[0];
      run_case($sformatf("rand%0d", r), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
